bk_serial_add_ctrl: RTL and testbench

BK_SERIAL_ADD_CTRL -- requirements
Module: bk_serial_add_ctrl

---
 rtl/bk_serial_add_ctrl.sv | 161 ++++++++++++++++
 tb/tb_bk_serial_add_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_serial_add_ctrl.sv
// Two-requester serial adder: one Brent-Kung 4-bit slice is time-shared to add
// W-bit operands one nibble per cycle, with round-robin arbitration on contention.

module Brent_Kung_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g_s;
  logic [3:0] p_s;
  logic       c1_s;
  logic       c2_s;
  logic       c3_s;
  logic       g32_s;
  logic       p32_s;

  assign g_s   = a & b;
  assign p_s   = a ^ b;
  // carry-in is folded into bit 0 so the prefix tree yields carries directly
  assign c1_s  = g_s[0] | (p_s[0] & cin);
  assign c2_s  = g_s[1] | (p_s[1] & c1_s);
  assign g32_s = g_s[3] | (p_s[3] & g_s[2]);
  assign p32_s = p_s[3] & p_s[2];
  assign c3_s  = g_s[2] | (p_s[2] & c2_s);
  assign cout  = g32_s | (p32_s & c2_s);
  assign sum   = p_s ^ {c3_s, c2_s, c1_s, cin};
endmodule

module bk_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [4*NIBBLES-1:0] req0_a_i,
  input  logic [4*NIBBLES-1:0] req0_b_i,
  input  logic                 req0_cin_i,
  input  logic [4*NIBBLES-1:0] req1_a_i,
  input  logic [4*NIBBLES-1:0] req1_b_i,
  input  logic                 req1_cin_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_id_o,
  output logic [4*NIBBLES-1:0] rsp_sum_o,
  output logic                 rsp_cout_o,
  output logic                 busy_o
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          carry_r;
  logic          last_grant_r;
  logic          id_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-5:0]  result_r;
  logic [1:0]    grant_s;
  logic          accept_s;
  logic          acc_id_s;
  logic [3:0]    nib_a_s;
  logic [3:0]    nib_b_s;
  logic [3:0]    nib_sum_s;
  logic          nib_cout_s;

  // Grant selection: a lone requester wins, contention goes to the one not served last
  always_comb begin
    grant_s = 2'b00;
    case (req_valid_i)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
  end

  assign req_ready_o = (rst_ni && (state_r == IDLE)) ? grant_s : 2'b00;
  assign accept_s    = |req_ready_o;
  assign acc_id_s    = req_ready_o[1];
  assign nib_a_s     = a_r[{cnt_r, 2'b00} +: 4];
  assign nib_b_s     = b_r[{cnt_r, 2'b00} +: 4];

  Brent_Kung_adder_4bit u_bk (
    .a    (nib_a_s),
    .b    (nib_b_s),
    .cin  (carry_r),
    .sum  (nib_sum_s),
    .cout (nib_cout_s)
  );

  // Control FSM with operand capture, nibble accumulation and registered response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      carry_r      <= 1'b0;
      last_grant_r <= 1'b1;
      id_r         <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
      result_r     <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= 1'b0;
      rsp_sum_o    <= '0;
      rsp_cout_o   <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r          <= acc_id_s ? req1_a_i : req0_a_i;
            b_r          <= acc_id_s ? req1_b_i : req0_b_i;
            carry_r      <= acc_id_s ? req1_cin_i : req0_cin_i;
            id_r         <= acc_id_s;
            last_grant_r <= acc_id_s;
            cnt_r        <= '0;
            busy_o       <= 1'b1;
            state_r      <= CALC;
          end
        end
        CALC: begin
          carry_r <= nib_cout_s;
          // top nibble goes straight to the response; lower ones accumulate
          if (cnt_r == LAST_CNT) begin
            rsp_sum_o   <= {nib_sum_s, result_r};
            rsp_cout_o  <= nib_cout_s;
            rsp_id_o    <= id_r;
            rsp_valid_o <= 1'b1;
            state_r     <= DONE;
          end else begin
            result_r[{cnt_r, 2'b00} +: 4] <= nib_sum_s;
            cnt_r                         <= cnt_r + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bk_serial_add_ctrl.sv
// Randomized and directed bench for bk_serial_add_ctrl against a transaction-level
// model: sums from plain arithmetic, grants from the round-robin rule.
module tb_bk_serial_add_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int n_acc = 0;
  int n_done = 0;

  bit           m_busy;
  bit           m_last;
  bit           m_id;
  int           m_accept;
  logic [W:0]   m_res;
  logic [W-1:0] m_hold_sum;
  bit           m_hold_cout;
  bit           m_hold_id;

  bit g_id_q[$];
  int g_edge_q[$];

  bk_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req0_a_i    (req0_a),
    .req0_b_i    (req0_b),
    .req0_cin_i  (req0_cin),
    .req1_a_i    (req1_a),
    .req1_b_i    (req1_b),
    .req1_cin_i  (req1_cin),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum),
    .rsp_cout_o  (rsp_cout),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_last = 1'b1;
    m_hold_sum = '0;
    m_hold_cout = 1'b0;
    m_hold_id = 1'b0;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic step(output bit vld_seen);
    logic [1:0] exp_rdy;
    bit exp_vld;
    bit gid;
    @(negedge clk);
    exp_rdy = 2'b00;
    if (!m_busy) begin
      if (req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
      else exp_rdy = req_valid;
    end
    exp_vld = m_busy && (edge_cnt >= m_accept + NIBBLES);
    if (exp_vld) begin
      m_hold_sum  = m_res[W-1:0];
      m_hold_cout = m_res[W];
      m_hold_id   = m_id;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rsp_sum", 32'(rsp_sum), 32'(m_hold_sum));
    chk("rsp_cout", 32'(rsp_cout), 32'(m_hold_cout));
    chk("rsp_id", 32'(rsp_id), 32'(m_hold_id));
    if (req_ready != 2'b00) begin
      g_id_q.push_back(req_ready[1]);
      g_edge_q.push_back(edge_cnt + 1);
    end
    vld_seen = exp_vld;
    @(posedge clk);
    edge_cnt++;
    if (exp_rdy != 2'b00) begin
      gid = exp_rdy[1];
      if (gid) m_res = {1'b0, req1_a} + {1'b0, req1_b} + {{W{1'b0}}, req1_cin};
      else     m_res = {1'b0, req0_a} + {1'b0, req0_b} + {{W{1'b0}}, req0_cin};
      m_id = gid;
      m_last = gid;
      m_accept = edge_cnt;
      m_busy = 1'b1;
      n_acc++;
    end else if (exp_vld && rsp_ready) begin
      m_busy = 1'b0;
      n_done++;
    end
    #1;
  endtask

  task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input int stall);
    int acc0, done0, st;
    bit v;
    acc0 = n_acc;
    done0 = n_done;
    st = 0;
    if (id) begin req1_a = a; req1_b = b; req1_cin = cin; end
    else    begin req0_a = a; req0_b = b; req0_cin = cin; end
    req_valid = id ? 2'b10 : 2'b01;
    for (int i = 0; i < 40 && n_done == done0; i++) begin
      rsp_ready = (st >= stall);
      step(v);
      if (n_acc != acc0) begin
        req_valid = 2'b00;
        // operands change after acceptance must not matter
        req0_a = W'($urandom); req1_a = W'($urandom);
      end
      if (v) st++;
    end
    if (n_done == done0) chk("op_timeout", 32'd0, 32'd1);
    rsp_ready = 1'b1;
  endtask

  initial begin
    bit v;
    int acc0;
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(rsp_sum), 32'd0);
    chk("rst_cout_id", 32'({rsp_cout, rsp_id}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention from reset: grants alternate starting with requester 0
    g_id_q.delete(); g_edge_q.delete();
    for (int i = 0; i < 60 && g_id_q.size() < 4; i++) begin
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
      step(v);
    end
    chk("contend_count", 32'(g_id_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < g_id_q.size(); i++) chk("grant_order", 32'(g_id_q[i]), 32'(i % 2));
    req_valid = 2'b00;
    for (int i = 0; i < 40 && m_busy; i++) step(v);

    do_op(1'b0, 16'h1234, 16'h4321, 1'b0, 0);
    chk("vec_5555", 32'({rsp_cout, rsp_sum}), 32'h05555);
    chk("vec_5555_id", 32'(rsp_id), 32'd0);
    do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 0);
    chk("chain1", 32'({rsp_cout, rsp_sum}), 32'h10000);
    do_op(1'b1, 16'hFFFF, 16'h0000, 1'b1, 0);
    chk("chain2", 32'({rsp_cout, rsp_sum}), 32'h10000);
    do_op(1'b0, 16'h8000, 16'h8000, 1'b1, 0);
    chk("chain3", 32'({rsp_cout, rsp_sum}), 32'h10001);

    // Backpressure: three stalled DONE cycles, then an idle cycle
    do_op(1'b1, 16'hA5A5, 16'h1111, 1'b1, 3);
    chk("bp_sum", 32'({rsp_cout, rsp_sum}), 32'h0B6B7);
    step(v);

    // Reset two cycles into CALC
    acc0 = n_acc;
    req0_a = 16'h7777; req0_b = 16'h1234; req0_cin = 1'b1;
    req_valid = 2'b01;
    for (int i = 0; i < 10 && n_acc == acc0; i++) step(v);
    req_valid = 2'b00;
    step(v); step(v);
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum", 32'(rsp_sum), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_cout_id", 32'({rsp_cout, rsp_id}), 32'd0);
    model_reset();
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b1;
    do_op(1'b1, 16'h00FF, 16'h0F01, 1'b0, 0);
    chk("post_rst_sum", 32'({rsp_cout, rsp_sum}), 32'h01000);
    chk("post_rst_id", 32'(rsp_id), 32'd1);

    // Only requester 1, back to back: issue interval is NIBBLES+2
    g_id_q.delete(); g_edge_q.delete();
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    for (int i = 0; i < 30 && g_id_q.size() < 2; i++) step(v);
    req_valid = 2'b00;
    chk("b2b_count", 32'(g_id_q.size()), 32'd2);
    if (g_id_q.size() == 2) begin
      chk("b2b_id0", 32'(g_id_q[0]), 32'd1);
      chk("b2b_id1", 32'(g_id_q[1]), 32'd1);
      chk("b2b_interval", 32'(g_edge_q[1] - g_edge_q[0]), 32'(NIBBLES + 2));
    end
    for (int i = 0; i < 40 && m_busy; i++) step(v);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(v);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && m_busy; i++) step(v);
    chk("drain", 32'(m_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
